rsa_sequencer: RTL and testbench
================================

RSA_SEQUENCER -- requirements
Module: rsa_sequencer

Interface
REQ-001 SHALL have parameter MSG_BYTES, default 2, message width in bytes.
REQ-002 SHALL have parameter KEY_BYTES, default 4, exponent/modulus/result width in bytes.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1_000_000, maximum cycles to wait for the engine.
REQ-004 SHALL use one clock and an asynchronous, active-high reset: clk_in  input  1  clock; rst_in  input  1  asynchronous active-high reset.
REQ-005 SHALL have req_valid_in  input  1  one-cycle request strobe from the deserializer.
REQ-006 SHALL have message_in  input  8*MSG_BYTES, exponent_in  input  8*KEY_BYTES, modulus_in  input  8*KEY_BYTES  request operands.
REQ-007 SHALL have start_out  output  1, base_out  output  8*KEY_BYTES, exp_out  output  8*KEY_BYTES, mod_out  output  8*KEY_BYTES  modexp engine launch.
REQ-008 SHALL have engine_done_in  input  1 and engine_result_in  input  8*KEY_BYTES  engine completion.
REQ-009 SHALL have tx_valid_out  output  1, tx_data_out  output  8*KEY_BYTES, tx_ready_in  input  1  result handshake to the serializer.
REQ-010 SHALL have status_out  output  2 (00 ok, 01 bad operand, 10 timeout) and drop_count_out  output  8  saturating dropped-request count.
REQ-011 SHALL have busy_out  output  1, high whenever the FSM is not IDLE.

Function
REQ-012 SHALL hold one pending-request buffer (operands plus a full flag); base_out is message_in zero-extended to 8*KEY_BYTES.
REQ-013 SHALL load req_valid_in into the buffer when the buffer is empty, or when it is full and being consumed in the same cycle.
REQ-014 SHALL drop req_valid_in when the buffer is full and not consumed that cycle, and increment drop_count_out, saturating at 255.
REQ-015 SHALL implement the FSM states IDLE, CHECK, LAUNCH, WAIT, SEND.
REQ-016 IDLE: when the buffer is full, SHALL consume it into the working registers and go to CHECK the next cycle.
REQ-017 CHECK: SHALL go to SEND with status 01 and tx_data 0 if the modulus is 0, the modulus is 1, or the zero-extended message is >= the modulus; otherwise SHALL go to LAUNCH.
REQ-018 LAUNCH: SHALL drive start_out high for exactly one cycle, with base_out/exp_out/mod_out valid and held stable until the FSM leaves WAIT, then go to WAIT.
REQ-019 WAIT: SHALL count cycles from 0; when engine_done_in is high, SHALL latch engine_result_in and go to SEND with status 00.
REQ-020 WAIT: if the counter reaches TIMEOUT_CYCLES-1 without engine_done_in, SHALL go to SEND with status 10 and tx_data 0; engine_done_in in that same cycle takes priority (status 00).
REQ-021 SEND: SHALL hold tx_valid_out high, with tx_data_out and status_out stable, until tx_ready_in is high; on that cycle SHALL return to IDLE.
REQ-022 SHALL ignore engine_done_in outside WAIT.
REQ-023 Latency: request to start_out SHALL be 3 cycles from an idle, empty state (buffer load, IDLE->CHECK, CHECK->LAUNCH).
REQ-024 status_out SHALL hold its last value until the next SEND updates it.

Reset
REQ-025 On rst_in, SHALL immediately set the FSM to IDLE and clear the buffer, working registers and timeout counter.
REQ-026 On rst_in, SHALL drive start_out, tx_valid_out and busy_out to 0, and set tx_data_out, base_out, exp_out, mod_out, status_out and drop_count_out to 0.
REQ-027 Reset asserted during WAIT or SEND SHALL abandon the transaction with no tx_valid_out pulse afterwards.

Verification
REQ-028 Operands msg=5, exp=3, mod=33; engine returns 26 two cycles after start_out; tx_ready_in held high -> start_out pulses once with base_out=5, tx_data_out=26, status_out=00.
REQ-029 mod=0, then a second request with msg=40, mod=33 -> no start_out for either; each gives tx_valid_out with tx_data_out=0, status_out=01.
REQ-030 TIMEOUT_CYCLES=16, engine never done -> tx_valid_out asserts 16 cycles after entering WAIT with status_out=10, tx_data_out=0.
REQ-031 Three requests A, B, C while A is in WAIT -> B is buffered and processed after A; C is dropped and drop_count_out=1; 300 drops in total leave drop_count_out=255.
REQ-032 tx_ready_in held low 10 cycles in SEND -> tx_valid_out/tx_data_out stable for all 10 cycles; the buffered request is not started until the handshake completes.
REQ-033 rst_in asserted asynchronously mid-WAIT, then engine_done_in -> all outputs 0, FSM in IDLE, no tx_valid_out.

Source files
------------

// File: rtl/rsa_sequencer.sv
// Request sequencer for a modular-exponentiation engine: buffers one request,
// screens operands, launches the engine and hands the result to the serializer.
module rsa_sequencer #(
    parameter int MSG_BYTES      = 2,
    parameter int KEY_BYTES      = 4,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   req_valid_in,
    input  logic [8*MSG_BYTES-1:0] message_in,
    input  logic [8*KEY_BYTES-1:0] exponent_in,
    input  logic [8*KEY_BYTES-1:0] modulus_in,
    output logic                   start_out,
    output logic [8*KEY_BYTES-1:0] base_out,
    output logic [8*KEY_BYTES-1:0] exp_out,
    output logic [8*KEY_BYTES-1:0] mod_out,
    input  logic                   engine_done_in,
    input  logic [8*KEY_BYTES-1:0] engine_result_in,
    output logic                   tx_valid_out,
    output logic [8*KEY_BYTES-1:0] tx_data_out,
    input  logic                   tx_ready_in,
    output logic [1:0]             status_out,
    output logic [7:0]             drop_count_out,
    output logic                   busy_out
);

    localparam int MW = 8 * MSG_BYTES;
    localparam int KW = 8 * KEY_BYTES;
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_BAD_OP  = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_LAUNCH,
        S_WAIT,
        S_SEND
    } state_t;

    state_t          r_state;
    state_t          w_next;

    logic            r_buf_full;
    logic [MW-1:0]   r_buf_msg;
    logic [KW-1:0]   r_buf_exp;
    logic [KW-1:0]   r_buf_mod;

    logic [KW-1:0]   r_base;
    logic [KW-1:0]   r_exp;
    logic [KW-1:0]   r_mod;
    logic [CW-1:0]   r_cnt;
    logic [KW-1:0]   r_tx_data;
    logic [1:0]      r_status;
    logic [7:0]      r_drop;

    logic            w_consume;
    logic            w_load;
    logic            w_drop;
    logic            w_bad;
    logic            w_send_load;
    logic [KW-1:0]   w_send_data;
    logic [1:0]      w_send_status;

    assign w_bad = (r_mod == '0) || (r_mod == KW'(1)) || (r_base >= r_mod);

    // A full buffer may be refilled in the same cycle IDLE drains it
    assign w_load = req_valid_in && (!r_buf_full || w_consume);
    assign w_drop = req_valid_in && r_buf_full && !w_consume;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        w_consume     = 1'b0;
        w_send_load   = 1'b0;
        w_send_data   = '0;
        w_send_status = ST_OK;
        unique case (r_state)
            S_IDLE: begin
                if (r_buf_full) begin
                    w_consume = 1'b1;
                    w_next    = S_CHECK;
                end
            end
            S_CHECK: begin
                if (w_bad) begin
                    w_next        = S_SEND;
                    w_send_load   = 1'b1;
                    w_send_status = ST_BAD_OP;
                end else begin
                    w_next = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                w_next = S_WAIT;
            end
            S_WAIT: begin
                if (engine_done_in) begin
                    w_next        = S_SEND;
                    w_send_load   = 1'b1;
                    w_send_data   = engine_result_in;
                    w_send_status = ST_OK;
                end else if (r_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                    w_next        = S_SEND;
                    w_send_load   = 1'b1;
                    w_send_status = ST_TIMEOUT;
                end
            end
            S_SEND: begin
                if (tx_ready_in) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_buf_full <= 1'b0;
            r_buf_msg  <= '0;
            r_buf_exp  <= '0;
            r_buf_mod  <= '0;
            r_drop     <= '0;
        end else begin
            if (w_load) begin
                r_buf_full <= 1'b1;
                r_buf_msg  <= message_in;
                r_buf_exp  <= exponent_in;
                r_buf_mod  <= modulus_in;
            end else if (w_consume) begin
                r_buf_full <= 1'b0;
            end
            if (w_drop && (r_drop != 8'hFF)) begin
                r_drop <= r_drop + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_base    <= '0;
            r_exp     <= '0;
            r_mod     <= '0;
            r_cnt     <= '0;
            r_tx_data <= '0;
            r_status  <= ST_OK;
        end else begin
            if (w_consume) begin
                r_base <= KW'(r_buf_msg);
                r_exp  <= r_buf_exp;
                r_mod  <= r_buf_mod;
            end
            if (r_state == S_WAIT) begin
                r_cnt <= r_cnt + CW'(1);
            end else begin
                r_cnt <= '0;
            end
            if (w_send_load) begin
                r_tx_data <= w_send_data;
                r_status  <= w_send_status;
            end
        end
    end

    assign start_out      = (r_state == S_LAUNCH);
    assign base_out       = r_base;
    assign exp_out        = r_exp;
    assign mod_out        = r_mod;
    assign tx_valid_out   = (r_state == S_SEND);
    assign tx_data_out    = r_tx_data;
    assign status_out     = r_status;
    assign drop_count_out = r_drop;
    assign busy_out       = (r_state != S_IDLE);

endmodule

// File: tb/tb_rsa_sequencer.sv
// Scoreboard bench for rsa_sequencer with a behavioural modexp engine.
module tb_rsa_sequencer;

    logic        clk_in;
    logic        rst_in;
    logic        req_valid_in;
    logic [15:0] message_in;
    logic [31:0] exponent_in;
    logic [31:0] modulus_in;
    logic        start_out;
    logic [31:0] base_out;
    logic [31:0] exp_out;
    logic [31:0] mod_out;
    logic        engine_done_in;
    logic [31:0] engine_result_in;
    logic        tx_valid_out;
    logic [31:0] tx_data_out;
    logic        tx_ready_in;
    logic [1:0]  status_out;
    logic [7:0]  drop_count_out;
    logic        busy_out;

    int total = 0;
    int bad   = 0;
    int n_start = 0;
    int eng_delay = 2;
    bit eng_on = 1'b1;
    logic [33:0] sb[$];

    rsa_sequencer #(
        .MSG_BYTES(2),
        .KEY_BYTES(4),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .req_valid_in(req_valid_in),
        .message_in(message_in),
        .exponent_in(exponent_in),
        .modulus_in(modulus_in),
        .start_out(start_out),
        .base_out(base_out),
        .exp_out(exp_out),
        .mod_out(mod_out),
        .engine_done_in(engine_done_in),
        .engine_result_in(engine_result_in),
        .tx_valid_out(tx_valid_out),
        .tx_data_out(tx_data_out),
        .tx_ready_in(tx_ready_in),
        .status_out(status_out),
        .drop_count_out(drop_count_out),
        .busy_out(busy_out)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] modexp(input logic [31:0] b,
                                          input logic [31:0] e,
                                          input logic [31:0] m);
        logic [63:0] r;
        r = 64'd1 % m;
        for (int i = 31; i >= 0; i--) begin
            r = (r * r) % m;
            if (e[i]) r = (r * b) % m;
        end
        return r[31:0];
    endfunction

    // Engine: answers eng_delay cycles after seeing start_out
    initial begin
        logic [31:0] res;
        engine_done_in   = 1'b0;
        engine_result_in = '0;
        forever begin
            @(negedge clk_in);
            if (start_out && eng_on) begin
                res = modexp(base_out, exp_out, mod_out);
                repeat (eng_delay) @(posedge clk_in);
                #1;
                engine_done_in   = 1'b1;
                engine_result_in = res;
                @(posedge clk_in);
                #1;
                engine_done_in = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk_in);
            if (start_out) n_start++;
        end
    end

    // Monitor: compare every completed result handshake
    initial begin
        logic [33:0] e;
        forever begin
            @(negedge clk_in);
            if (!rst_in && tx_valid_out && tx_ready_in) begin
                if (sb.size() == 0) begin
                    chk("unexpected_tx", 64'(tx_valid_out), 0);
                end else begin
                    e = sb.pop_front();
                    chk("tx_data", 64'(tx_data_out), 64'(e[33:2]));
                    chk("tx_status", 64'(status_out), 64'(e[1:0]));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic send_req(input logic [15:0] m, input logic [31:0] e,
                            input logic [31:0] md);
        req_valid_in = 1'b1;
        message_in   = m;
        exponent_in  = e;
        modulus_in   = md;
        @(posedge clk_in);
        #1;
        req_valid_in = 1'b0;
    endtask

    task automatic expect_tx(input logic [31:0] d, input logic [1:0] s);
        sb.push_back({d, s});
    endtask

    task automatic wait_start();
        int n = 0;
        while (!start_out && n < 100) begin
            @(posedge clk_in);
            #1;
            n++;
        end
        if (!start_out) chk("wait_start_bound", 64'(start_out), 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy_out || sb.size() != 0) && n < 1000) begin
            @(posedge clk_in);
            #1;
            n++;
        end
        if (busy_out) chk("wait_idle_bound", 64'(busy_out), 0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_start"}, 64'(start_out), 0);
        chk({tag, "_txv"}, 64'(tx_valid_out), 0);
        chk({tag, "_busy"}, 64'(busy_out), 0);
        chk({tag, "_txd"}, 64'(tx_data_out), 0);
        chk({tag, "_base"}, 64'(base_out), 0);
        chk({tag, "_exp"}, 64'(exp_out), 0);
        chk({tag, "_mod"}, 64'(mod_out), 0);
        chk({tag, "_status"}, 64'(status_out), 0);
        chk({tag, "_drop"}, 64'(drop_count_out), 0);
    endtask

    initial begin
        int lat;
        int n;
        int s0;
        int txv;
        int bsy;
        rst_in       = 1'b1;
        req_valid_in = 1'b0;
        message_in   = '0;
        exponent_in  = '0;
        modulus_in   = '0;
        tx_ready_in  = 1'b1;
        repeat (3) @(posedge clk_in);
        #1;
        chk_zero("rst");
        rst_in = 1'b0;
        @(posedge clk_in);
        #1;

        // Normal transaction: 5^3 mod 33 = 26
        s0 = n_start;
        eng_delay = 2;
        expect_tx(32'd26, 2'b00);
        send_req(16'd5, 32'd3, 32'd33);
        lat = 1;
        while (!start_out && lat < 20) begin
            @(posedge clk_in);
            #1;
            lat++;
        end
        chk("latency", 64'(lat), 3);
        chk("base_out", 64'(base_out), 5);
        chk("exp_out", 64'(exp_out), 3);
        chk("mod_out", 64'(mod_out), 33);
        @(posedge clk_in);
        #1;
        chk("start_one_cycle", 64'(start_out), 0);
        chk("base_hold", 64'(base_out), 5);
        wait_idle();
        chk("starts_basic", 64'(n_start - s0), 1);

        // Bad operands: mod=0, msg>=mod, mod=1, msg==mod
        s0 = n_start;
        expect_tx(32'd0, 2'b01);
        expect_tx(32'd0, 2'b01);
        send_req(16'd7, 32'd3, 32'd0);
        send_req(16'd40, 32'd3, 32'd33);
        wait_idle();
        expect_tx(32'd0, 2'b01);
        send_req(16'd0, 32'd1, 32'd1);
        wait_idle();
        expect_tx(32'd0, 2'b01);
        send_req(16'd33, 32'd3, 32'd33);
        wait_idle();
        chk("starts_badop", 64'(n_start - s0), 0);
        chk("drop_none", 64'(drop_count_out), 0);

        // Engine never answers: timeout after 16 WAIT cycles
        eng_on = 1'b0;
        expect_tx(32'd0, 2'b10);
        send_req(16'd2, 32'd2, 32'd7);
        wait_start();
        @(posedge clk_in);
        n = 0;
        while (n < 40) begin
            @(posedge clk_in);
            #1;
            n++;
            if (tx_valid_out) break;
        end
        chk("timeout_cycles", 64'(n), 16);
        chk("timeout_data", 64'(tx_data_out), 0);
        chk("timeout_status", 64'(status_out), 2);
        wait_idle();
        chk("status_hold", 64'(status_out), 2);
        eng_on = 1'b1;

        // A in WAIT, B buffered, C dropped; backpressure in SEND
        s0 = n_start;
        eng_delay = 10;
        tx_ready_in = 1'b0;
        expect_tx(32'd6, 2'b00);
        expect_tx(32'd4, 2'b00);
        send_req(16'd2, 32'd5, 32'd13);
        wait_start();
        send_req(16'd3, 32'd4, 32'd7);
        send_req(16'd9, 32'd9, 32'd11);
        chk("drop_one", 64'(drop_count_out), 1);
        n = 0;
        while (!tx_valid_out && n < 100) begin
            @(posedge clk_in);
            #1;
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            chk("hold_valid", 64'(tx_valid_out), 1);
            chk("hold_data", 64'(tx_data_out), 6);
            chk("hold_status", 64'(status_out), 0);
            @(posedge clk_in);
            #1;
        end
        chk("b_not_started", 64'(n_start - s0), 1);
        for (int i = 0; i < 299; i++) send_req(16'd1, 32'd1, 32'd1);
        chk("drop_saturate", 64'(drop_count_out), 255);
        chk("b_still_waiting", 64'(n_start - s0), 1);
        tx_ready_in = 1'b1;
        wait_idle();
        chk("starts_ab", 64'(n_start - s0), 2);

        // Asynchronous reset mid-WAIT, engine answers afterwards
        eng_delay = 4;
        send_req(16'd5, 32'd3, 32'd33);
        wait_start();
        @(posedge clk_in);
        #3;
        rst_in = 1'b1;
        #1;
        chk_zero("async_rst");
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        txv = 0;
        bsy = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk_in);
            #1;
            if (tx_valid_out) txv++;
            if (busy_out) bsy++;
        end
        chk("rst_no_txv", 64'(txv), 0);
        chk("rst_no_busy", 64'(bsy), 0);
        chk_zero("post_rst");

        chk("sb_empty", 64'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
